// File: rtl/pcie_cfg_pkg.sv
// Shared types and constants for the PCIe configuration-space APB requester.
package pcie_cfg_pkg;

    localparam int APB_DATA_W = 32;

    // Configuration register byte offsets within the config-space block
    localparam logic [11:0] CFG_VID_DID = 12'h000;
    localparam logic [11:0] CFG_CMD_STS = 12'h004;
    localparam logic [11:0] CFG_BAR0    = 12'h010;
    localparam logic [11:0] CFG_SPECIAL = 12'h040;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_mst_state_t;

endpackage

// File: rtl/pcie_cfg_apb_master.sv
// APB requester for the PCIe config-space block: one outstanding transfer,
// completer wait states with a saturating timeout, local misalignment reject.
module pcie_cfg_apb_master
    import pcie_cfg_pkg::*;
#(
    parameter int ADDR_W         = 12,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_W-1:0]     req_addr_i,
    input  logic                  req_write_i,
    input  logic [APB_DATA_W-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [APB_DATA_W-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  rsp_timeout_o,
    output logic                  psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [ADDR_W-1:0]     paddr_o,
    output logic [APB_DATA_W-1:0] pwdata_o,
    input  logic                  pready_i,
    input  logic                  pslverr_i,
    input  logic [APB_DATA_W-1:0] prdata_i
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    apb_mst_state_t          state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        cnt_inc;
    logic                    timeout_hit;
    logic                    req_ready_q, req_ready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [APB_DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;
    logic                    rsp_timeout_q, rsp_timeout_d;
    logic                    psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic                    pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]       paddr_q, paddr_d;
    logic [APB_DATA_W-1:0]   pwdata_q, pwdata_d;

    // Next-state and next-output logic; every output is computed one cycle ahead so it leaves a flop
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        req_ready_d   = req_ready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        cnt_inc       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        timeout_hit   = (TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_MAX);

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    req_ready_d = 1'b0;
                    if (req_addr_i[1:0] != 2'b00) begin
                        rsp_valid_d   = 1'b1;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b0;
                        rsp_rdata_d   = '0;
                        state_d       = RESP;
                    end else begin
                        psel_d    = 1'b1;
                        penable_d = 1'b0;
                        paddr_d   = req_addr_i;
                        pwrite_d  = req_write_i;
                        pwdata_d  = req_wdata_i;
                        state_d   = SETUP;
                    end
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (pready_i || timeout_hit) begin
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = pready_i ? pslverr_i : 1'b1;
                    rsp_timeout_d = !pready_i;
                    rsp_rdata_d   = (pready_i && !pslverr_i && !pwrite_q) ? prdata_i : '0;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    pwrite_d      = 1'b0;
                    paddr_d       = '0;
                    pwdata_d      = '0;
                    state_d       = RESP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d   = 1'b0;
                    rsp_err_d     = 1'b0;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = '0;
                    req_ready_d   = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any transfer and reopens the request channel
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
        end
    end

    assign req_ready_o   = req_ready_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_err_o     = rsp_err_q;
    assign rsp_timeout_o = rsp_timeout_q;
    assign psel_o        = psel_q;
    assign penable_o     = penable_q;
    assign pwrite_o      = pwrite_q;
    assign paddr_o       = paddr_q;
    assign pwdata_o      = pwdata_q;

endmodule

// File: tb/tb_pcie_cfg_apb_master.sv
// Self-checking bench for pcie_cfg_apb_master: directed cases then random
// transfers against a transaction-level reference model.
module tb_pcie_cfg_apb_master;
    import pcie_cfg_pkg::*;

    localparam int ADDR_W         = 12;
    localparam int TIMEOUT_CYCLES = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid_i;
    logic              req_ready_o;
    logic [ADDR_W-1:0] req_addr_i;
    logic              req_write_i;
    logic [31:0]       req_wdata_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [31:0]       rsp_rdata_o;
    logic              rsp_err_o;
    logic              rsp_timeout_o;
    logic              psel_o;
    logic              penable_o;
    logic              pwrite_o;
    logic [ADDR_W-1:0] paddr_o;
    logic [31:0]       pwdata_o;
    logic              pready_i;
    logic              pslverr_i;
    logic [31:0]       prdata_i;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_mem [16];
    logic [31:0] slave_mem [16];
    int          cur_waits = 0;
    logic        cur_err   = 1'b0;
    int          acc_cnt   = 0;

    pcie_cfg_apb_master #(
        .ADDR_W         (ADDR_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_addr_i    (req_addr_i),
        .req_write_i   (req_write_i),
        .req_wdata_i   (req_wdata_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_rdata_o   (rsp_rdata_o),
        .rsp_err_o     (rsp_err_o),
        .rsp_timeout_o (rsp_timeout_o),
        .psel_o        (psel_o),
        .penable_o     (penable_o),
        .pwrite_o      (pwrite_o),
        .paddr_o       (paddr_o),
        .pwdata_o      (pwdata_o),
        .pready_i      (pready_i),
        .pslverr_i     (pslverr_i),
        .prdata_i      (prdata_i)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Completer model: stalls for cur_waits ACCESS cycles, then completes with data or an error
    always @(negedge clk) begin
        if (psel_o && penable_o) begin
            if (acc_cnt == cur_waits) begin
                pready_i  = 1'b1;
                pslverr_i = cur_err;
                if (cur_err) begin
                    prdata_i = 32'hDEAD_BEEF;
                end else if (pwrite_o) begin
                    slave_mem[paddr_o[5:2]] = pwdata_o;
                    prdata_i = $urandom;
                end else begin
                    prdata_i = slave_mem[paddr_o[5:2]];
                end
            end else begin
                pready_i  = 1'b0;
                pslverr_i = 1'($urandom_range(0, 1));
                prdata_i  = $urandom;
            end
            acc_cnt++;
        end else begin
            pready_i  = 1'b0;
            pslverr_i = 1'b0;
            prdata_i  = $urandom;
            acc_cnt   = 0;
        end
    end

    // One comparison: counts it, and on mismatch counts and reports the failure
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // One complete request/response transaction checked against the reference model
    task automatic applyStimulus(input logic [ADDR_W-1:0] addr, input logic wr, input logic [31:0] wdata,
                                 input int waits, input logic serr, input int hold);
        logic        exp_err;
        logic        exp_to;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_acc;
        int          exp_setup;
        int          lat;
        int          acc;
        int          setup;
        logic        apb_ok;
        logic        busy_ok;
        logic        stable_ok;
        logic [33:0] held;

        if (addr[1:0] != 2'b00) begin
            exp_err = 1'b1; exp_to = 1'b0; exp_rdata = 32'h0;
            exp_lat = 1; exp_acc = 0; exp_setup = 0;
        end else if (waits >= TIMEOUT_CYCLES) begin
            exp_err = 1'b1; exp_to = 1'b1; exp_rdata = 32'h0;
            exp_lat = 2 + TIMEOUT_CYCLES; exp_acc = TIMEOUT_CYCLES; exp_setup = 1;
        end else begin
            exp_err = serr; exp_to = 1'b0;
            exp_rdata = (wr || serr) ? 32'h0 : model_mem[addr[5:2]];
            exp_lat = 3 + waits; exp_acc = waits + 1; exp_setup = 1;
            if (wr && !serr) model_mem[addr[5:2]] = wdata;
        end

        cur_waits = waits;
        cur_err   = serr;
        @(negedge clk);
        checkOutput("req_ready_idle", 32'(req_ready_o), 32'd1);
        req_valid_i = 1'b1;
        req_addr_i  = addr;
        req_write_i = wr;
        req_wdata_i = wdata;
        @(posedge clk);
        #1;
        req_valid_i = 1'($urandom_range(0, 1));
        req_addr_i  = ADDR_W'($urandom);
        req_write_i = 1'($urandom);
        req_wdata_i = $urandom;

        lat = 0; acc = 0; setup = 0; apb_ok = 1'b1; busy_ok = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (rsp_valid_o) begin
                lat = c;
                break;
            end
            if (psel_o && penable_o) acc++;
            else if (psel_o) setup++;
            else if (penable_o) apb_ok = 1'b0;
            if (psel_o && (paddr_o !== addr || pwrite_o !== wr || (wr && pwdata_o !== wdata))) apb_ok = 1'b0;
            if (req_ready_o) busy_ok = 1'b0;
        end

        checkOutput("latency", 32'(lat), 32'(exp_lat));
        checkOutput("access_cycles", 32'(acc), 32'(exp_acc));
        checkOutput("setup_cycles", 32'(setup), 32'(exp_setup));
        checkOutput("apb_stable", 32'(apb_ok), 32'd1);
        checkOutput("req_ready_busy", 32'(busy_ok), 32'd1);
        checkOutput("rsp_err", 32'(rsp_err_o), 32'(exp_err));
        checkOutput("rsp_timeout", 32'(rsp_timeout_o), 32'(exp_to));
        checkOutput("rsp_rdata", rsp_rdata_o, exp_rdata);
        checkOutput("apb_idle_in_resp",
                    32'(psel_o | penable_o | pwrite_o | (|paddr_o) | (|pwdata_o)), 32'd0);

        held      = {rsp_err_o, rsp_timeout_o, rsp_rdata_o};
        stable_ok = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (!rsp_valid_o || {rsp_err_o, rsp_timeout_o, rsp_rdata_o} !== held) stable_ok = 1'b0;
        end
        if (hold > 0) checkOutput("rsp_hold_stable", 32'(stable_ok), 32'd1);

        rsp_ready_i = 1'b1;
        req_valid_i = 1'b0;
        @(posedge clk);
        #1;
        rsp_ready_i = 1'b0;
        @(negedge clk);
        checkOutput("rsp_done", 32'(rsp_valid_o), 32'd0);
        checkOutput("req_ready_after", 32'(req_ready_o), 32'd1);
    endtask

    // Directed test-plan steps, a reset during ACCESS, then random transfers
    initial begin
        logic        seen;
        logic        quiet;
        logic [3:0]  idx;
        logic [1:0]  off;
        int          r;
        int          w;

        for (int i = 0; i < 16; i++) begin
            model_mem[i] = 32'h0;
            slave_mem[i] = 32'h0;
        end
        rst = 1'b1;
        req_valid_i = 1'b0; req_addr_i = '0; req_write_i = 1'b0; req_wdata_i = 32'h0;
        rsp_ready_i = 1'b0;
        pready_i = 1'b0; pslverr_i = 1'b0; prdata_i = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_outputs_zero",
                    32'(rsp_valid_o | rsp_err_o | rsp_timeout_o | (|rsp_rdata_o) | psel_o | penable_o |
                        pwrite_o | (|paddr_o) | (|pwdata_o)), 32'd0);
        checkOutput("reset_req_ready", 32'(req_ready_o), 32'd1);
        rst = 1'b0;

        $display("[TB] directed transfers");
        applyStimulus(CFG_VID_DID, 1'b1, 32'h1234_ABCD, 0, 1'b0, 0);
        applyStimulus(CFG_VID_DID, 1'b0, 32'h0, 0, 1'b0, 0);
        applyStimulus(CFG_BAR0, 1'b1, 32'hCAFE_0010, 0, 1'b0, 0);
        applyStimulus(CFG_BAR0, 1'b0, 32'h0, 3, 1'b0, 0);
        applyStimulus(CFG_CMD_STS, 1'b0, 32'h0, 100, 1'b0, 0);
        applyStimulus(12'h006, 1'b0, 32'h0, 0, 1'b0, 0);
        applyStimulus(CFG_CMD_STS, 1'b0, 32'h0, 1, 1'b1, 0);
        applyStimulus(CFG_CMD_STS, 1'b0, 32'h0, TIMEOUT_CYCLES - 1, 1'b0, 0);
        applyStimulus(CFG_CMD_STS, 1'b1, 32'h5555_AAAA, TIMEOUT_CYCLES, 1'b0, 0);
        applyStimulus(CFG_BAR0, 1'b1, 32'h0BAD_F00D, 2, 1'b0, 5);

        $display("[TB] reset during ACCESS");
        cur_waits = 8;
        cur_err   = 1'b0;
        @(negedge clk);
        req_valid_i = 1'b1; req_addr_i = CFG_BAR0; req_write_i = 1'b0;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (psel_o && penable_o) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("rst_reached_access", 32'(seen), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_outputs_zero",
                    32'(rsp_valid_o | rsp_err_o | rsp_timeout_o | (|rsp_rdata_o) | psel_o | penable_o |
                        pwrite_o | (|paddr_o) | (|pwdata_o)), 32'd0);
        checkOutput("rst_req_ready", 32'(req_ready_o), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        quiet = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rsp_valid_o || psel_o || !req_ready_o) quiet = 1'b0;
        end
        checkOutput("rst_no_response", 32'(quiet), 32'd1);

        $display("[TB] random transfers");
        for (int t = 0; t < 40; t++) begin
            idx = 4'($urandom);
            off = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            r   = $urandom_range(0, 9);
            w   = (r < 7) ? (r % 5) : ((r == 7) ? TIMEOUT_CYCLES - 1 : ((r == 8) ? TIMEOUT_CYCLES : 20));
            applyStimulus({6'b0, idx, off}, 1'($urandom), $urandom, w,
                          ($urandom_range(0, 7) == 0), $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
